// File: rtl/bram_access_unit.sv
// bram_access_unit
// Initiator-side controller for the single-port, negedge-sampled bram.
// Byte-addressed load/store requests from the core arrive over a valid/ready
// handshake and become word-port cycles on the bram. Results (load data or
// store completion, plus an error flag) go back over a second valid/ready
// handshake. Sub-word stores are read-modify-write because the bram has no
// byte enables.
//
// Optional feature macro: BRAM_ACCESS_SUBWORD_EN
//   defined     : byte/halfword loads and stores, MERGE state and lane logic
//   not defined : word accesses only; sizes 0, 1, 3 return rsp_err and
//                 req_signed is ignored
//
// Ports
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE)
//   req_write       1 = store, 0 = load
//   req_size        0 byte, 1 halfword, 2 word, 3 illegal
//   req_signed      sign-extend sub-word loads
//   req_addr        byte address
//   req_wdata       store data, right-aligned
//   rsp_valid/ready response handshake
//   rsp_rdata       extended load result, 0 for stores and errors
//   rsp_err         misaligned, out-of-range or illegal-size request
//   mem_addr        word index to bram (req_addr >> 2), registered
//   mem_write       bram write strobe, registered
//   mem_wdata       bram write data, registered
//   mem_rdata       bram read data
module bram_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

`ifdef BRAM_ACCESS_SUBWORD_EN
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  state_t state;
  logic   wr_q;
  logic   req_bad;

`ifdef BRAM_ACCESS_SUBWORD_EN
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Little-endian lane select; halfword lanes are 0 or 2, so the same
  // byte-granular shift serves both sizes.
  function automatic logic [DATA_WIDTH-1:0] load_lane(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane,
    input logic                  sgn
  );
    logic [DATA_WIDTH-1:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_lane = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_lane = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: load_lane = word;
    endcase
  endfunction

  // Insert the new byte/halfword into the old word, other lanes untouched.
  function automatic logic [DATA_WIDTH-1:0] merge_lane(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] mask;
    base = (size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask = base << {lane, 3'b000};
    merge_lane = (old_word & ~mask) | ((wdata & base) << {lane, 3'b000});
  endfunction
`else
  logic unused_signed;
  assign unused_signed = req_signed;
`endif

  // Request legality: alignment, size and word-index range.
  always_comb begin
    req_bad = 1'b0;
    if (req_size == 2'd3) req_bad = 1'b1;
    if (req_size == SZ_HALF && req_addr[0]) req_bad = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_bad = 1'b1;
`ifndef BRAM_ACCESS_SUBWORD_EN
    if (req_size != SZ_WORD) req_bad = 1'b1;
`endif
    if ((req_addr >> 2) >= DEPTH_W) req_bad = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      wr_q      <= 1'b0;
`ifdef BRAM_ACCESS_SUBWORD_EN
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      lane_q    <= 2'd0;
      wdata_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            wr_q      <= req_write;
`ifdef BRAM_ACCESS_SUBWORD_EN
            size_q    <= req_size;
            signed_q  <= req_signed;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
`endif
            if (req_bad) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_err   <= 1'b0;
              mem_addr  <= req_addr >> 2;
              mem_write <= req_write && (req_size == SZ_WORD);
              if (req_write && (req_size == SZ_WORD)) mem_wdata <= req_wdata;
              state     <= ACCESS;
            end
          end
        end

        // The bram acts on the negedge inside this cycle; its data is
        // valid at the following posedge.
        ACCESS: begin
          if (!wr_q) begin
`ifdef BRAM_ACCESS_SUBWORD_EN
            rsp_rdata <= load_lane(mem_rdata, size_q, lane_q, signed_q);
`else
            rsp_rdata <= mem_rdata;
`endif
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef BRAM_ACCESS_SUBWORD_EN
          end else if (size_q != SZ_WORD) begin
            mem_wdata <= merge_lane(mem_rdata, wdata_q, size_q, lane_q);
            mem_write <= 1'b1;
            state     <= MERGE;
`endif
          end else begin
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

`ifdef BRAM_ACCESS_SUBWORD_EN
        MERGE: begin
          mem_write <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`endif

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
